imm_extend: RTL and testbench
=============================

// Module: imm_extend
// PURPOSE
//  Immediate extender for the ARMv4 single-cycle datapath decode stage.
//  Takes instruction bits [23:0] and the ImmSrc control from the main decoder.
//  Produces the 32-bit ExtImm operand for the ALU (data-processing, LDR/STR)
//  or the branch target adder. The output is registered: one clock of latency.
// PARAMETERS
//  none (all widths fixed by the ARMv4 encoding)
// PORTS
//  clk                     in   1   system clock, rising-edge active
//  rst_n                   in   1   asynchronous, active-low reset
//  valid_in                in   1   immSrc/second_source_register valid this cycle
//  immSrc                  in   2   immediate format select (see BEHAVIOUR)
//  second_source_register  in   24  instruction bits Instr[23:0]
//  extImm                  out  32  extended immediate, registered
//  valid_out               out  1   extImm holds a result computed from a valid_in beat
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset: while rst_n=0, extImm=32'h0000_0000 and valid_out=0, independent of clk.
//  - Latency: on each rising clk edge with valid_in=1:
//      extImm <= f(immSrc, second_source_register), valid_out <= 1.
//  - With valid_in=0 at the edge: extImm holds its value, valid_out <= 0.
//  - f, with I = second_source_register:
//      2'b00  DP imm8:  {24'h0, I[7:0]}              zero-extend, no rotation
//      2'b01  mem imm12: {20'h0, I[11:0]}            zero-extend
//      2'b10  branch:   {{6{I[23]}}, I[23:0], 2'b00} sign-extend, word shift (<<2)
//      2'b11  reserved: 32'h0000_0000
//  - Bits of I not named for the selected format are ignored.
//  - Sign-extension width rule: the result is exactly 32 bits. I[23] fills [31:26].
//  - No X propagation: every immSrc encoding yields a defined value.
//  - Back-to-back: a new valid_in every cycle gives a new result every cycle.
//    There is no stall or backpressure.
//  - Reset deasserting mid-stream: the first edge after rst_n rises samples normally.
//  - No handshake beyond valid_in/valid_out.
// STRUCTURE
//  - Shared package arm_pkg:
//      typedef enum logic [1:0] imm_src_t {IMM_DP8=2'b00, IMM_MEM12=2'b01,
//        IMM_BR24=2'b10, IMM_RSVD=2'b11}
//      localparams INSTR_IMM_W=24, WORD_W=32
//  - One sub-module is natural: imm_extend_comb. It contains the purely
//    combinational f(). The top level adds the output/valid register.
// TESTING
//  - Reset: rst_n=0 asynchronously mid-cycle -> extImm=0x00000000, valid_out=0 immediately.
//  - immSrc=00, I=0xFFFFFF, valid_in=1 -> next edge extImm=0x000000FF, valid_out=1.
//  - immSrc=01, I=0xFFFFFF -> extImm=0x00000FFF.
//  - immSrc=10, I=0xFFFFFF -> extImm=0xFFFFFFFC.
//    immSrc=10, I=0x7FFFFF -> extImm=0x01FFFFFC.
//  - immSrc=11, I=0xABCDEF -> extImm=0x00000000.
//    Then valid_in=0 for 2 cycles -> extImm held, valid_out=0.
//  - Back-to-back stream of the four cases at 1 per clock -> results in order,
//    1-cycle latency, valid_out high every cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared immediate-format encodings and widths for the ARMv4 decode stage.
package arm_pkg;
   typedef enum logic [1:0] {
      IMM_DP8   = 2'b00,
      IMM_MEM12 = 2'b01,
      IMM_BR24  = 2'b10,
      IMM_RSVD  = 2'b11
   } imm_src_t;
   localparam int INSTR_IMM_W = 24;
   localparam int WORD_W      = 32;
endpackage

// File: rtl/imm_extend_comb.sv
// imm_extend_comb: combinational immediate extension selected by the ImmSrc format.
module imm_extend_comb
   import arm_pkg::*;
(
   input  logic [1:0]             imm_src,
   input  logic [INSTR_IMM_W-1:0] instr_imm,
   output logic [WORD_W-1:0]      ext_imm
);
   imm_src_t src;
   assign src = imm_src_t'(imm_src);
   // Reserved encoding resolves to zero so no X ever reaches the ALU.
   always_comb begin
      ext_imm = (src == IMM_DP8)   ? {24'h0, instr_imm[7:0]} :
                (src == IMM_MEM12) ? {20'h0, instr_imm[11:0]} :
                (src == IMM_BR24)  ? {{6{instr_imm[23]}}, instr_imm, 2'b00} :
                                     '0;
   end
endmodule

// File: rtl/imm_extend.sv
// imm_extend: registered immediate extender; one cycle latency, holds value when idle.
module imm_extend
   import arm_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_in,
   input  logic [1:0]             immSrc,
   input  logic [INSTR_IMM_W-1:0] second_source_register,
   output logic [WORD_W-1:0]      extImm,
   output logic                   valid_out
);
   logic [WORD_W-1:0] ext_comb;
   logic [WORD_W-1:0] ext_imm_d, ext_imm_q;
   logic              valid_d, valid_q;
   imm_extend_comb u_comb (
      .imm_src   (immSrc),
      .instr_imm (second_source_register),
      .ext_imm   (ext_comb)
   );
   always_comb begin
      ext_imm_d = valid_in ? ext_comb : ext_imm_q;
      valid_d   = valid_in;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_imm_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         ext_imm_q <= ext_imm_d;
         valid_q   <= valid_d;
      end
   end
   assign extImm    = ext_imm_q;
   assign valid_out = valid_q;
endmodule

// File: tb/tb_imm_extend.sv
// tb_imm_extend: directed self-checking bench for imm_extend.
module tb_imm_extend;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [1:0]  immSrc = 2'b00;
   logic [23:0] second_source_register = 24'h0;
   logic [31:0] extImm;
   logic        valid_out;
   int tests = 0;
   int fails = 0;

   imm_extend dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .valid_in               (valid_in),
      .immSrc                 (immSrc),
      .second_source_register (second_source_register),
      .extImm                 (extImm),
      .valid_out              (valid_out)
   );

   always #5 clk = ~clk;

   logic [1:0]  v_src [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
   logic [23:0] v_imm [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h7FFFFF,
                              24'hABCDEF, 24'hABCD12, 24'h800345, 24'h000001};
   logic [31:0] v_exp [8] = '{32'h000000FF, 32'h00000FFF, 32'hFFFFFFFC, 32'h01FFFFFC,
                              32'h00000000, 32'h00000012, 32'h00000345, 32'h00000004};

   task automatic test_reset;
      #2;
      tests++;
      if (extImm !== 32'h0 || valid_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_initial: extImm=%h valid_out=%b, want 00000000/0", extImm, valid_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      valid_in = 1'b1;
      immSrc = 2'b10;
      second_source_register = 24'hFFFFFF;
      @(posedge clk);
      #1;
      tests++;
      if (extImm !== 32'hFFFFFFFC || valid_out !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_first_edge: extImm=%h valid_out=%b, want FFFFFFFC/1", extImm, valid_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (extImm !== 32'h0 || valid_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_async_midcycle: extImm=%h valid_out=%b, want 00000000/0", extImm, valid_out);
      end
      @(posedge clk);
      #1;
      tests++;
      if (extImm !== 32'h0 || valid_out !== 1'b0) begin
         fails++;
         $display("FAIL reset_held_over_edge: extImm=%h valid_out=%b, want 00000000/0", extImm, valid_out);
      end
      @(negedge clk);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_formats;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         valid_in = 1'b1;
         immSrc = v_src[k];
         second_source_register = v_imm[k];
         @(negedge clk);
         valid_in = 1'b0;
         immSrc = ~v_src[k];
         second_source_register = ~v_imm[k];
         #1;
         tests++;
         if (extImm !== v_exp[k] || valid_out !== 1'b1) begin
            fails++;
            $display("FAIL format_%0d src=%b I=%h: extImm=%h valid_out=%b, want %h/1",
                     k, v_src[k], v_imm[k], extImm, valid_out, v_exp[k]);
         end
      end
   endtask

   task automatic test_hold(input int idx);
      @(negedge clk);
      valid_in = 1'b1;
      immSrc = v_src[idx];
      second_source_register = v_imm[idx];
      @(negedge clk);
      valid_in = 1'b0;
      immSrc = 2'b01;
      second_source_register = 24'h123456;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         tests++;
         if (extImm !== v_exp[idx] || valid_out !== 1'b0) begin
            fails++;
            $display("FAIL hold_%0d_cycle%0d: extImm=%h valid_out=%b, want %h/0",
                     idx, c, extImm, valid_out, v_exp[idx]);
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         valid_in = 1'b1;
         immSrc = v_src[k];
         second_source_register = v_imm[k];
         @(posedge clk);
         #1;
         tests++;
         if (extImm !== v_exp[k] || valid_out !== 1'b1) begin
            fails++;
            $display("FAIL b2b_%0d: extImm=%h valid_out=%b, want %h/1", k, extImm, valid_out, v_exp[k]);
         end
      end
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (extImm !== v_exp[4] || valid_out !== 1'b0) begin
         fails++;
         $display("FAIL b2b_drain: extImm=%h valid_out=%b, want %h/0", extImm, valid_out, v_exp[4]);
      end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_hold(4);
      test_hold(2);
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
